// File: rtl/element_serializer.sv
// Element serializer: accepts wide elements and streams them out one byte at a
// time, MSB first. A holding register lets the next element wait behind the
// active one, so consecutive elements leave without a gap between them.
module element_serializer #(
    parameter int ELEMENT_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ELEMENT_WIDTH*8-1:0] element,
    input  logic                       element_valid,
    output logic                       element_ready,
    output logic [7:0]                 byte_out,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic                       byte_last,
    output logic                       busy,
    output logic [15:0]                elements_sent
);

    localparam int EW = ELEMENT_WIDTH * 8;
    localparam int IW = (ELEMENT_WIDTH > 1) ? $clog2(ELEMENT_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ELEMENT_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [EW-1:0]   shift_r;
    logic [EW-1:0]   shift_s;
    logic [EW-1:0]   hold_r;
    logic [EW-1:0]   hold_s;
    logic            hold_full_r;
    logic            hold_full_s;
    logic [IW-1:0]   index_r;
    logic [IW-1:0]   index_s;
    logic            last_r;
    logic            last_s;
    logic            busy_r;
    logic            busy_s;
    logic [15:0]     sent_r;
    logic [15:0]     sent_s;
    logic            accept_s;
    logic            handshake_s;
    logic            at_last_s;

    // The active byte always sits in the top byte of the shift register.
    assign element_ready = !reset && !hold_full_r;
    assign byte_valid    = (state_r == SHIFT);
    assign byte_out      = shift_r[EW-1 -: 8];
    assign byte_last     = last_r;
    assign busy          = busy_r;
    assign elements_sent = sent_r;

    assign accept_s    = element_valid && element_ready;
    assign handshake_s = byte_valid && byte_ready;
    assign at_last_s   = (index_r == LAST_IDX);

    // Next-state and datapath decisions for both storage registers.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        index_s     = index_r;
        sent_s      = sent_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    shift_s = element;
                    index_s = {IW{1'b0}};
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (handshake_s) begin
                    if (at_last_s) begin
                        // Element finished: refill from holding, from the
                        // input, or fall back to idle.
                        sent_s  = sent_r + 16'd1;
                        index_s = {IW{1'b0}};
                        if (hold_full_r) begin
                            shift_s     = hold_r;
                            hold_s      = {EW{1'b0}};
                            hold_full_s = 1'b0;
                        end else if (accept_s) begin
                            shift_s = element;
                        end else begin
                            shift_s = {EW{1'b0}};
                            state_s = IDLE;
                        end
                    end else begin
                        shift_s = shift_r << 8;
                        index_s = index_r + 1'b1;
                        if (accept_s) begin
                            hold_s      = element;
                            hold_full_s = 1'b1;
                        end else begin
                            hold_full_s = hold_full_r;
                        end
                    end
                end else if (accept_s) begin
                    hold_s      = element;
                    hold_full_s = 1'b1;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s     = IDLE;
                shift_s     = {EW{1'b0}};
                hold_s      = {EW{1'b0}};
                hold_full_s = 1'b0;
                index_s     = {IW{1'b0}};
            end
        endcase
        last_s = (state_s == SHIFT) && (index_s == LAST_IDX);
        busy_s = (state_s == SHIFT) || hold_full_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r     <= {EW{1'b0}};
            hold_r      <= {EW{1'b0}};
            hold_full_r <= 1'b0;
            index_r     <= {IW{1'b0}};
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            sent_r      <= 16'd0;
        end else begin
            shift_r     <= shift_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            index_r     <= index_s;
            last_r      <= last_s;
            busy_r      <= busy_s;
            sent_r      <= sent_s;
        end
    end

endmodule

// File: tb/tb_element_serializer.sv
// Testbench for element_serializer: directed vector table, hand-written corner
// sequences, randomized traffic against a queue-based reference, and a
// counter-wrap run on a single-byte-element instance.
module tb_element_serializer;

    localparam int W = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- ELEMENT_WIDTH = 3 instance ----------------
    logic          reset = 1'b1;
    logic [23:0]   element = 24'h0;
    logic          element_valid = 1'b0;
    logic          element_ready;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic          byte_last;
    logic          busy;
    logic [15:0]   elements_sent;

    element_serializer #(.ELEMENT_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .element(element), .element_valid(element_valid),
        .element_ready(element_ready), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy),
        .elements_sent(elements_sent)
    );

    // ---------------- ELEMENT_WIDTH = 1 instance ----------------
    logic          u_reset = 1'b1;
    logic [7:0]    u_element = 8'h0;
    logic          u_valid = 1'b0;
    logic          u_ready_out;
    logic [7:0]    u_byte_out;
    logic          u_byte_valid;
    logic          u_byte_ready = 1'b0;
    logic          u_byte_last;
    logic          u_busy;
    logic [15:0]   u_sent;

    element_serializer #(.ELEMENT_WIDTH(1)) dut1 (
        .clk(clk), .reset(u_reset), .element(u_element), .element_valid(u_valid),
        .element_ready(u_ready_out), .byte_out(u_byte_out), .byte_valid(u_byte_valid),
        .byte_ready(u_byte_ready), .byte_last(u_byte_last), .busy(u_busy),
        .elements_sent(u_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for the W=3 instance ----------------
    // Accepted elements wait in order; pos counts bytes already sent of the front one.
    logic [23:0] q[$];
    int          pos = 0;
    int          cnt = 0;
    bit          armed = 1'b0;
    logic [23:0] front_sh;

    // Compare outputs against the model, then apply the transfers of the coming edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("sb_valid", 32'(byte_valid), 32'(q.size() > 0));
            chk("sb_busy", 32'(busy), 32'(q.size() > 0));
            chk("sb_sent", 32'(elements_sent), 32'(cnt[15:0]));
            chk("sb_ready", 32'(element_ready), 32'(!reset && q.size() < 2));
            if (q.size() > 0) begin
                front_sh = q[0] >> (8 * (W - 1 - pos));
                chk("sb_byte", 32'(byte_out), 32'(front_sh[7:0]));
                chk("sb_last", 32'(byte_last), 32'(pos == W - 1));
            end else begin
                chk("sb_byte_idle", 32'(byte_out), 32'h0);
                chk("sb_last_idle", 32'(byte_last), 32'h0);
            end
        end
        if (reset) begin
            q.delete();
            pos = 0;
            cnt = 0;
            armed = 1'b1;
        end else if (armed) begin
            if (byte_valid && byte_ready) begin
                if (pos == W - 1) begin
                    void'(q.pop_front());
                    pos = 0;
                    cnt++;
                end else begin
                    pos++;
                end
            end
            if (element_valid && element_ready) q.push_back(element);
        end
    end

    // ---------------- reference model for the W=1 instance ----------------
    logic [7:0] uq[$];
    int         u_cnt = 0;
    bit         u_armed = 1'b0;
    bit         u_done = 1'b0;

    // Single-byte elements: every byte is last and each handshake counts one element.
    always @(negedge clk) begin
        if (u_armed) begin
            chk("w1_sent", 32'(u_sent), 32'(u_cnt[15:0]));
            chk("w1_valid", 32'(u_byte_valid), 32'(uq.size() > 0));
            if (uq.size() > 0) begin
                chk("w1_byte", 32'(u_byte_out), 32'(uq[0]));
                chk("w1_last", 32'(u_byte_last), 32'h1);
            end
        end
        if (u_reset) begin
            uq.delete();
            u_cnt = 0;
            u_armed = 1'b1;
        end else if (u_armed) begin
            if (u_byte_valid && u_byte_ready) begin
                void'(uq.pop_front());
                u_cnt++;
            end
            if (u_valid && u_ready_out) uq.push_back(u_element);
        end
    end

    // Counter-wrap run: 65536 back-to-back single-byte elements.
    initial begin
        bit seen_ffff = 1'b0;
        bit seen_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        u_reset = 1'b0;
        u_valid = 1'b1;
        u_byte_ready = 1'b1;
        u_element = 8'($urandom);
        for (int c = 0; c < 70000 && u_cnt < 65536; c++) begin
            @(posedge clk);
            #2;
            u_element = 8'($urandom);
            if (u_cnt == 65535 && !seen_ffff) begin
                seen_ffff = 1'b1;
                chk("w1_sent_ffff", 32'(u_sent), 32'h0000FFFF);
            end
            if (u_cnt == 65536 && !seen_zero) begin
                seen_zero = 1'b1;
                chk("w1_sent_wrap", 32'(u_sent), 32'h0);
            end
        end
        if (!seen_ffff || !seen_zero) chk("w1_wrap_reached", 32'(seen_ffff && seen_zero), 32'h1);
        u_valid = 1'b0;
        repeat (3) @(posedge clk);
        u_done = 1'b1;
    end

    // ---------------- directed helpers ----------------
    task automatic step(input logic v, input logic [23:0] e, input logic r);
        element_valid = v;
        element = e;
        byte_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic bv, input logic [7:0] bo, input logic bl);
        chk({n, "_valid"}, 32'(byte_valid), 32'(bv));
        chk({n, "_byte"}, 32'(byte_out), 32'(bo));
        chk({n, "_last"}, 32'(byte_last), 32'(bl));
    endtask

    typedef struct {
        logic        v;
        logic [23:0] e;
        logic        r;
        logic        bv;
        logic [7:0]  bo;
        logic        bl;
        logic        bsy;
        logic [15:0] sent;
        logic        er;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] seq[6];
        // Single element, then the same element with a 5-cycle stall on 0xB2.
        tbl[0]  = '{1'b1, 24'hA1B2C3, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 16'd0, 1'b1};
        tbl[1]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 16'd0, 1'b1};
        tbl[2]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 16'd0, 1'b1};
        tbl[3]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1, 1'b1};
        tbl[4]  = '{1'b1, 24'hA1B2C3, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[5]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 16'd1, 1'b1};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[11] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 16'd1, 1'b1};
        tbl[12] = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2, 1'b1};

        // Reset state.
        @(posedge clk);
        #1;
        expect_out("rst", 1'b0, 8'h00, 1'b0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sent", 32'(elements_sent), 32'h0);
        chk("rst_ready", 32'(element_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(element_ready), 32'h1);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].e, tbl[i].r);
            expect_out($sformatf("tbl%0d", i), tbl[i].bv, tbl[i].bo, tbl[i].bl);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_sent", i), 32'(elements_sent), 32'(tbl[i].sent));
            chk($sformatf("tbl%0d_ready", i), 32'(element_ready), 32'(tbl[i].er));
        end

        // Two elements accepted on consecutive cycles stream without a gap.
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        step(1'b1, 24'h112233, 1'b1);
        expect_out("b2b0", 1'b1, seq[0], 1'b0);
        step(1'b1, 24'h445566, 1'b1);
        expect_out("b2b1", 1'b1, seq[1], 1'b0);
        chk("b2b1_ready", 32'(element_ready), 32'h0);
        for (int i = 2; i < 6; i++) begin
            step(1'b0, 24'h0, 1'b1);
            expect_out($sformatf("b2b%0d", i), 1'b1, seq[i], 1'(i == 2 || i == 5));
            chk($sformatf("b2b%0d_ready", i), 32'(element_ready), 32'(i != 2));
        end
        step(1'b0, 24'h0, 1'b1);
        expect_out("b2b_end", 1'b0, 8'h00, 1'b0);
        chk("b2b_sent", 32'(elements_sent), 32'd4);

        // New element accepted on the last-byte handshake with holding empty.
        step(1'b1, 24'h0A0B0C, 1'b1);
        expect_out("sim0", 1'b1, 8'h0A, 1'b0);
        step(1'b0, 24'h0, 1'b1);
        step(1'b0, 24'h0, 1'b1);
        expect_out("sim2", 1'b1, 8'h0C, 1'b1);
        step(1'b1, 24'h0D0E0F, 1'b1);
        expect_out("sim3", 1'b1, 8'h0D, 1'b0);
        step(1'b0, 24'h0, 1'b1);
        step(1'b0, 24'h0, 1'b1);
        expect_out("sim5", 1'b1, 8'h0F, 1'b1);
        step(1'b0, 24'h0, 1'b1);
        expect_out("sim_end", 1'b0, 8'h00, 1'b0);
        chk("sim_sent", 32'(elements_sent), 32'd6);

        // Reset with 0xB2 pending and holding full; reset beats accept/handshake.
        step(1'b1, 24'hA1B2C3, 1'b1);
        step(1'b1, 24'h445566, 1'b1);
        expect_out("rmid0", 1'b1, 8'hB2, 1'b0);
        chk("rmid0_busy", 32'(busy), 32'h1);
        step(1'b0, 24'h0, 1'b0);
        reset = 1'b1;
        step(1'b1, 24'h778899, 1'b1);
        expect_out("rmid1", 1'b0, 8'h00, 1'b0);
        chk("rmid1_busy", 32'(busy), 32'h0);
        chk("rmid1_sent", 32'(elements_sent), 32'h0);
        chk("rmid1_ready", 32'(element_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("rmid_rel_ready", 32'(element_ready), 32'h1);
        step(1'b1, 24'h010203, 1'b1);
        expect_out("rnew0", 1'b1, 8'h01, 1'b0);
        step(1'b0, 24'h0, 1'b1);
        expect_out("rnew1", 1'b1, 8'h02, 1'b0);
        step(1'b0, 24'h0, 1'b1);
        expect_out("rnew2", 1'b1, 8'h03, 1'b1);
        step(1'b0, 24'h0, 1'b1);
        expect_out("rnew3", 1'b0, 8'h00, 1'b0);
        chk("rnew_sent", 32'(elements_sent), 32'h1);

        // Randomized traffic, checked by the reference model every cycle.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            step(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        reset = 1'b0;
        for (int c = 0; c < 12; c++) step(1'b0, 24'h0, 1'b1);
        chk("drain_idle", 32'(byte_valid), 32'h0);

        for (int c = 0; c < 80000 && !u_done; c++) @(posedge clk);
        if (!u_done) chk("w1_timeout", 32'(u_done), 32'h1);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/element_serializer.md
ELEMENT_SERIALIZER -- requirements
Module: element_serializer

Interface
REQ-001 Parameter ELEMENT_WIDTH, default 3, number of 8-bit bytes per element; legal range 1..8.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 element  input  ELEMENT_WIDTH*8  element to transmit; byte 0 is bits [ELEMENT_WIDTH*8-1 : ELEMENT_WIDTH*8-8] (MSB).
REQ-005 element_valid  input  1  upstream element offered.
REQ-006 element_ready  output  1  serializer can accept an element this cycle.
REQ-007 byte_out  output  8  current outgoing byte.
REQ-008 byte_valid  output  1  byte_out is valid.
REQ-009 byte_ready  input  1  byte sink (e.g. UART transmitter) accepts byte_out this cycle.
REQ-010 byte_last  output  1  byte_out is the final byte of its element.
REQ-011 busy  output  1  any element held or in transmission.
REQ-012 elements_sent  output  16  count of fully transmitted elements.

Function
REQ-013 Element accept SHALL occur on a rising edge with element_valid && element_ready; byte handshake SHALL occur on a rising edge with byte_valid && byte_ready.
REQ-014 Storage: one shift register (active element) plus one holding register; element_ready = !reset && holding register empty (combinational).
REQ-015 States: IDLE (shift register empty, byte_valid=0) and SHIFT (shift register loaded, byte_valid=1).
REQ-016 IDLE + accept: element SHALL load into shift register, byte index = 0, state -> SHIFT; byte_valid high the following cycle (latency 1 cycle from accept to first byte).
REQ-017 SHIFT + accept: element SHALL load into holding register; element_ready low next cycle.
REQ-018 byte_out SHALL equal the byte at the current index, MSB first; byte_out and byte_last SHALL stay stable while byte_valid && !byte_ready.
REQ-019 Non-last byte handshake: index increments by 1, state stays SHIFT.
REQ-020 byte_last SHALL be 1 iff index == ELEMENT_WIDTH-1; with ELEMENT_WIDTH=1 every byte is last.
REQ-021 Last byte handshake with holding full: holding SHALL move to shift register same edge, index=0, holding empty, byte_valid stays 1 (no bubble).
REQ-022 Last byte handshake with holding empty and simultaneous accept: new element SHALL load directly into shift register, index=0, byte_valid stays 1; holding stays empty.
REQ-023 Last byte handshake with holding empty, no accept: state -> IDLE, byte_valid=0 next cycle.
REQ-024 elements_sent SHALL increment by 1 on each last-byte handshake, wrapping 0xFFFF -> 0x0000.
REQ-025 busy = (state == SHIFT) || holding full, registered-state derived, no glitching on inputs.
REQ-026 Elements SHALL be transmitted in acceptance order; no element dropped or duplicated.

Reset
REQ-027 While reset is high: state=IDLE, shift and holding registers cleared, index=0, byte_out=0x00, byte_valid=0, byte_last=0, busy=0, elements_sent=0, element_ready=0.
REQ-028 Reset mid-element SHALL discard active and held elements; no further bytes emitted; element_ready=1 first cycle after reset deasserts.
REQ-029 Reset SHALL dominate simultaneous accept or byte handshake in the same cycle.

Verification
REQ-030 ELEMENT_WIDTH=3, byte_ready=1, accept 0xA1B2C3 in IDLE -> bytes 0xA1,0xB2,0xC3 on three consecutive cycles starting 1 cycle after accept, byte_last only with 0xC3, elements_sent=1, then byte_valid=0.
REQ-031 Accept 0x112233 then 0x445566 on consecutive cycles, byte_ready=1 -> six contiguous bytes 0x11..0x66, element_ready low from cycle after second accept until 0x33 handshake, elements_sent=2.
REQ-032 Backpressure: byte_ready=0 for 5 cycles during 0xB2 of 0xA1B2C3 -> byte_out holds 0xB2, byte_valid=1, index unchanged; resumes with 0xC3 after release.
REQ-033 Simultaneous last-byte handshake and new accept with holding empty -> new element's byte 0 appears next cycle, byte_valid never drops.
REQ-034 Preload elements_sent=0xFFFF via 65535 elements with ELEMENT_WIDTH=1 then one more -> elements_sent=0x0000.
REQ-035 Reset asserted while 0xB2 pending with holding full -> next cycle byte_valid=0, busy=0, elements_sent=0; after deassert, new element 0x010203 transmits correctly with no stale bytes.
